down_counter: RTL and testbench
===============================

# down_counter

Loadable WIDTH-bit down-counter/timer with a small run-control state machine. Software or a controlling FSM loads a start value and gates counting with `enable`. The block then counts toward zero, raises a one-cycle `done` pulse at terminal count and returns to idle. It is the counting-down companion to the team's 4-bit up-counter and serves as the timeout and delay primitive in the same design.

## Interface
- `WIDTH`, default 4: counter width in bits (minimum 2).
- `clk` input 1: clock, all state on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous abort; forces the count to 0 and the state to IDLE.
- `load` input 1: synchronous load of `load_value`.
- `load_value` input WIDTH: start value, sampled only when `load`=1.
- `enable` input 1: active-high count enable; valid only in RUN.
- `count_out` output WIDTH: registered current count.
- `busy` output 1: registered; 1 while in RUN.
- `done` output 1: registered; one-cycle pulse on terminal count.
- `zero` output 1: combinational, `count_out`==0.

## Operation
- States:
  - IDLE: `count_out` holds; `enable` is ignored.
  - RUN: `count_out` decrements by 1 on each edge with `enable`=1 and holds when `enable`=0.
- Priority per edge: `rst_n` low > `clear` > `load` > decrement.
- `clear`=1: `count_out`<=0, next state IDLE, `done`<=0. Applies in any state.
- `load`=1, `load_value`!=0: `count_out`<=`load_value`, next state RUN. Applies from IDLE or RUN; a load in RUN restarts the count.
- `load`=1, `load_value`==0: `count_out`<=0, next state IDLE, no `done` pulse.
- Terminal count: in RUN with `count_out`==1, `enable`=1 and no `clear`/`load`:
  - `count_out`<=0, `done`<=1, next state IDLE.
  - With auto-reload compiled in, see Configuration.
- Expiry coincident with `load` or `clear`: the higher-priority action wins and `done` is not pulsed.
- No wrap-around: the count never decrements from 0. Arithmetic is unsigned, modulo 2^WIDTH never reached.
- `done` is 0 on every edge except the terminal-count edge.

## Timing
- Reset values: `count_out`=0, `busy`=0, `done`=0, `zero`=1. All are asserted asynchronously on `rst_n` falling, with no clock required. The block leaves reset in IDLE.
- Load at edge N: `count_out`=V and `busy`=1 after edge N.
- Latency: `done` rises exactly V enabled cycles after the load edge.
  - At the same edge `count_out` becomes 0 and `busy` falls (non-reload build).
- `done` width: exactly one clock.
- Input handling: all inputs are sampled on the rising edge. There are no combinational paths from inputs to registered outputs. `zero` depends only on `count_out`.

## Configuration
- Macro: `DOWN_COUNTER_AUTO_RELOAD_EN`.
- Defined:
  - A WIDTH-bit reload register captures `load_value` on every accepted nonzero load, and resets to 0.
  - On terminal count, `count_out`<=reload register, `done`<=1, and the state stays RUN with `busy` held at 1.
  - `count_out` therefore never shows 0 during free-running operation. It stops only on `clear`, a zero load, or reset.
- Undefined: no reload register is present. Terminal count returns to IDLE with `count_out`=0, as in Operation.

## Test plan
- Reset mid-run: load 9, run 3 enabled cycles, pulse `rst_n` low between edges -> immediately `count_out`=0, `busy`=0, `done`=0, `zero`=1.
- Basic count: load 5 with `enable` held 1 -> `count_out` 5,4,3,2,1,0. `done`=1 for exactly the edge reaching 0, where `busy` also falls; `count_out` then holds 0.
- Gated enable: load 15, toggle `enable` 1/0 each cycle -> one decrement per enabled cycle; `done` pulses after 15 enabled cycles (30 clocks).
- Collisions:
  - Load 3, run to 1, then apply `load`=1 with value 9 and `enable`=1 -> `count_out`=9, `busy`=1, no `done`.
  - Separately, at count 7 apply `clear` and `load` (value 4) together -> `count_out`=0, IDLE, no `done`.
- Zero load: in RUN at count 6, load 0 -> `count_out`=0, `busy`=0, `done` never asserted.
- Auto-reload, macro defined: load 2, hold `enable` 1 -> `count_out` 2,1,2,1,2…, `done` pulsing every 2nd edge, `busy` constant 1. Macro undefined: 2,1,0 with a single `done`.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down-counter/timer with a one-cycle done pulse at terminal count.
// Latency: outputs registered, 1 cycle from load; done rises V enabled cycles after load.
// Backpressure: none; enable gates decrements only, load/clear are always accepted.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset, leaves the block in IDLE
//   clear      - synchronous abort: count to 0, state to IDLE
//   load       - synchronous load of load_value (nonzero -> RUN, zero -> IDLE)
//   load_value - start value, sampled only while load=1
//   enable     - count enable, only honoured in RUN
//   count_out  - registered current count
//   busy       - registered, 1 while in RUN
//   done       - registered one-cycle pulse on terminal count
//   zero       - combinational, count_out == 0
//
// Optional feature: define DOWN_COUNTER_AUTO_RELOAD_EN to add a reload register.
// The count then restarts from the last nonzero load value at terminal count
// and the block keeps running until a clear, a zero load or reset.

module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             done_q;
    logic             done_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
`endif

    // State register: run-control state, count, done pulse (and reload value).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            done_q  <= done_nxt;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_nxt;
`endif
        end
    end

    // Next-state logic. Priority: clear > load > decrement. done is only
    // raised on the plain terminal-count path, so an expiry that coincides
    // with clear or load is swallowed by the higher-priority action.
    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        done_nxt  = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_nxt = reload_q;
`endif
        if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (load) begin
            if (load_value != '0) begin
                state_nxt = RUN;
                count_nxt = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                reload_nxt = load_value;
`endif
            end else begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        end else if (state_q == RUN && enable && count_q != '0) begin
            // count_q != 0 keeps the counter from ever wrapping below zero.
            if (count_q == WIDTH'(1)) begin
                done_nxt = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                state_nxt = RUN;
                count_nxt = reload_q;
`else
                state_nxt = IDLE;
                count_nxt = '0;
`endif
            end else begin
                count_nxt = count_q - WIDTH'(1);
            end
        end
    end

    // Outputs: busy is decoded straight from the state flop, so it stays a
    // registered output with no input-to-output path.
    always_comb begin
        count_out = count_q;
        busy      = (state_q == RUN);
        done      = done_q;
        zero      = (count_q == '0);
    end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: reference model feeds a scoreboard queue.
// Latency: one expected entry per clock, compared 1 time unit after the edge.
// Backpressure: not applicable; stimulus is driven every cycle on the falling edge.

module tb_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic [W-1:0] count_out;
    logic         busy;
    logic         done;
    logic         zero;

    down_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .count_out  (count_out),
        .busy       (busy),
        .done       (done),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_count;
    logic [W-1:0] m_reload;
    logic         m_busy;

    int done_seen;
    int cyc;
    int done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = '0;
        m_reload = '0;
        m_busy   = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, predict, then compare the DUT against the
    // queued prediction once the edge has settled.
    task automatic step(input logic c, input logic l, input logic [W-1:0] v, input logic e);
        exp_t x;
        logic m_done;
        @(negedge clk);
        clear      = c;
        load       = l;
        load_value = v;
        enable     = e;
        m_done = 1'b0;
        if (c) begin
            m_count = '0;
            m_busy  = 1'b0;
        end else if (l && v != '0) begin
            m_count  = v;
            m_reload = v;
            m_busy   = 1'b1;
        end else if (l) begin
            m_count = '0;
            m_busy  = 1'b0;
        end else if (m_busy && e) begin
            if (m_count == 1) begin
                m_done = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                m_count = m_reload;
`else
                m_count = '0;
                m_busy  = 1'b0;
`endif
            end else begin
                m_count = m_count - 1'b1;
            end
        end
        x.count = m_count;
        x.busy  = m_busy;
        x.done  = m_done;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk("count", 32'(count_out), 32'(x.count));
        chk("busy",  32'(busy),      32'(x.busy));
        chk("done",  32'(done),      32'(x.done));
        chk("zero",  32'(zero),      32'(x.count == '0));
        cyc++;
        if (done) begin
            done_seen++;
            if (done_cyc == 0) done_cyc = cyc;
        end
    endtask

    task automatic start_phase();
        done_seen = 0;
        done_cyc  = 0;
        cyc       = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0;
        model_reset();
        #12;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_zero",  32'(zero),      32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-run, asserted between edges
        start_phase();
        step(1'b0, 1'b1, W'(9), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("midrun_count_pre", 32'(count_out), 32'd6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_count", 32'(count_out), 32'd0);
        chk("midrun_rst_busy",  32'(busy),      32'd0);
        chk("midrun_rst_done",  32'(done),      32'd0);
        chk("midrun_rst_zero",  32'(zero),      32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic count: 5,4,3,2,1,0 with done on the edge reaching 0
        start_phase();
        step(1'b0, 1'b1, W'(5), 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("basic_done_cyc",   32'(done_cyc),  32'd6);
        chk("basic_done_count", 32'(done_seen), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Gated enable: 15 enabled cycles spread over 30 clocks
        step(1'b0, 1'b1, W'(15), 1'b0);
        start_phase();
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, '0, (i % 2) == 1);
        chk("gated_done_cyc", 32'(done_cyc), 32'd30);
        step(1'b1, 1'b0, '0, 1'b0);

        // Collision: reload while at 1 with enable high -> restart, no done
        start_phase();
        step(1'b0, 1'b1, W'(3), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, W'(9), 1'b1);
        chk("coll_load_count", 32'(count_out), 32'd9);
        chk("coll_load_done",  32'(done_seen), 32'd0);

        // Collision: clear + load together at count 7 -> clear wins
        start_phase();
        step(1'b0, 1'b1, W'(8), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, W'(4), 1'b1);
        chk("coll_clr_count", 32'(count_out), 32'd0);
        chk("coll_clr_busy",  32'(busy),      32'd0);
        // enable is ignored in IDLE
        step(1'b0, 1'b0, '0, 1'b1);
        chk("coll_clr_done", 32'(done_seen), 32'd0);

        // Zero load while running at 6
        start_phase();
        step(1'b0, 1'b1, W'(6), 1'b0);
        step(1'b0, 1'b1, W'(0), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("zload_busy", 32'(busy),      32'd0);
        chk("zload_done", 32'(done_seen), 32'd0);

        // Load 2 and free-run: reload build repeats 2,1; plain build stops at 0
        start_phase();
        step(1'b0, 1'b1, W'(2), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        chk("reload_done_count", 32'(done_seen), 32'd3);
        chk("reload_busy",       32'(busy),      32'd1);
`else
        chk("reload_done_count", 32'(done_seen), 32'd1);
        chk("reload_busy",       32'(busy),      32'd0);
`endif
        chk("reload_first_done", 32'(done_cyc), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
